shift_seq_unit: RTL and testbench

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

---
 rtl/shift_seq_unit.sv | 121 ++++++++++++
 tb/tb_shift_seq_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// Sequential shifter/rotator. Each accepted request runs one single-bit
// step per clock for 'amt' clocks, then holds the result until it is taken.
module shift_seq_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work_q;
  logic [1:0]       op_q;
  logic [AW-1:0]    cnt_q;
  logic             carry_q;

  logic             accept;
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  assign accept = in_valid && (state == IDLE);

  // One single-bit step of the captured operation on the working register.
  always_comb begin
    step_val   = work_q;
    step_carry = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_val   = {work_q[WIDTH-2:0], 1'b0};
        step_carry = work_q[WIDTH-1];
      end
      OP_SHR: begin
        step_val   = {1'b0, work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      OP_ROL: begin
        step_val   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        step_carry = work_q[WIDTH-1];
      end
      OP_ROR: begin
        step_val   = {work_q[0], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      default: begin
        step_val   = work_q;
        step_carry = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (amt == '0) ? DONE : RUN;
      RUN:  if (cnt_q == AW'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath only moves on accept and in RUN, so DONE/IDLE hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      op_q    <= OP_SHL;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      work_q  <= din;
      op_q    <= op;
      cnt_q   <= amt;
      carry_q <= 1'b0;
    end else if (state == RUN) begin
      work_q  <= step_val;
      carry_q <= step_carry;
      cnt_q   <= cnt_q - AW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign dout      = work_q;
  assign carry     = carry_q;
  assign zero      = (work_q == '0);

  // RUN is only entered with a nonzero count, so the counter never wraps.
  a_run_cnt_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (cnt_q != '0));

  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(dout) && $stable(carry) && out_valid));

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: constant vector table, hand-built
// corner sequences, and random requests checked against an arithmetic model.
module tb_shift_seq_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [3:0]    amt;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          carry;
  logic          zero;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   amt;
    logic [W-1:0] din;
    logic [W-1:0] exp_dout;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[9];

  shift_seq_unit #(.WIDTH(W), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .amt       (amt),
    .din       (din),
    .dout      (dout),
    .carry     (carry),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result from plain arithmetic on the whole operand.
  function automatic void model(input logic [1:0] o, input int n, input logic [W-1:0] d,
                                output logic [W-1:0] r, output logic c);
    logic [63:0] x, t;
    int k;
    x = 64'(d);
    k = n % W;
    case (o)
      2'b00: begin t = x << n; r = t[W-1:0]; c = (n == 0) ? 1'b0 : t[W]; end
      2'b01: begin t = x >> n; r = t[W-1:0]; t = x >> (n - 1); c = (n == 0) ? 1'b0 : t[0]; end
      2'b10: begin t = (x << k) | (x >> (W - k)); r = t[W-1:0]; c = (n == 0) ? 1'b0 : r[0]; end
      default: begin t = (x >> k) | (x << (W - k)); r = t[W-1:0]; c = (n == 0) ? 1'b0 : r[W-1]; end
    endcase
  endfunction

  // Present a request, wait for acceptance, then count edges to out_valid
  // while scrambling the request inputs, which the block must ignore.
  task automatic applyStimulus(input logic [1:0] o, input logic [3:0] a, input logic [W-1:0] d,
                               input string name);
    int guard, edges;
    @(negedge clk);
    in_valid = 1'b1; op = o; amt = a; din = d;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check_val({name, " accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      in_valid = 1'($urandom); op = 2'($urandom); amt = 4'($urandom); din = W'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check_val({name, " latency"}, 64'(edges), 64'(a));
  endtask

  // Compare the held result, then take it and confirm the return to IDLE.
  task automatic checkOutput(input logic [W-1:0] exp_d, input logic exp_c, input string name);
    check_val({name, " out_valid"}, 64'(out_valid), 1);
    check_val({name, " dout"},      64'(dout), 64'(exp_d));
    check_val({name, " carry"},     64'(carry), 64'(exp_c));
    check_val({name, " zero"},      64'(zero), 64'(exp_d == '0));
    check_val({name, " busy"},      64'(busy), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({name, " in_ready_after_take"}, 64'(in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] rd, held_d;
    logic         rc, held_c;

    vecs[0] = '{2'b10, 4'd1,  16'h8001, 16'h0003, 1'b1};
    vecs[1] = '{2'b01, 4'd4,  16'h00F0, 16'h000F, 1'b0};
    vecs[2] = '{2'b00, 4'd15, 16'hFFFF, 16'h8000, 1'b1};
    vecs[3] = '{2'b11, 4'd0,  16'h1234, 16'h1234, 1'b0};
    vecs[4] = '{2'b11, 4'd1,  16'h0001, 16'h8000, 1'b1};
    vecs[5] = '{2'b00, 4'd15, 16'h0001, 16'h8000, 1'b0};
    vecs[6] = '{2'b00, 4'd1,  16'h8000, 16'h0000, 1'b1};
    vecs[7] = '{2'b10, 4'd15, 16'h8001, 16'hC000, 1'b0};
    vecs[8] = '{2'b01, 4'd15, 16'h8000, 16'h0001, 1'b0};

    // Reset with a competing request at the same edge.
    rst = 1'b1; in_valid = 1'b1; op = 2'b00; amt = 4'd0; din = 16'hFFFF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset in_ready",  64'(in_ready), 1);
    check_val("reset out_valid", 64'(out_valid), 0);
    check_val("reset busy",      64'(busy), 0);
    check_val("reset dout",      64'(dout), 0);
    check_val("reset carry",     64'(carry), 0);
    check_val("reset zero",      64'(zero), 1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].amt, vecs[i].din, $sformatf("vec%0d", i));
      checkOutput(vecs[i].exp_dout, vecs[i].exp_carry, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, new requests ignored.
    model(2'b10, 5, 16'hA5C3, held_d, held_c);
    applyStimulus(2'b10, 4'd5, 16'hA5C3, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 2'b00; amt = 4'd0; din = 16'h1111;
      @(posedge clk); #1;
      check_val($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 1);
      check_val($sformatf("bp hold%0d dout", i),      64'(dout), 64'(held_d));
      check_val($sformatf("bp hold%0d carry", i),     64'(carry), 64'(held_c));
      check_val($sformatf("bp hold%0d zero", i),      64'(zero), 64'(held_d == '0));
      check_val($sformatf("bp hold%0d in_ready", i),  64'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp release out_valid", 64'(out_valid), 0);
    check_val("bp release in_ready",  64'(in_ready), 1);
    check_val("bp release dout",      64'(dout), 64'(held_d));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("bp next out_valid", 64'(out_valid), 1);
    check_val("bp next dout",      64'(dout), 16'h1111);
    check_val("bp next carry",     64'(carry), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset lands on the third edge of a 10-step SHL.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; amt = 4'd10; din = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("midrun busy", 64'(busy), 1);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    check_val("midrun rst in_ready",  64'(in_ready), 1);
    check_val("midrun rst out_valid", 64'(out_valid), 0);
    check_val("midrun rst dout",      64'(dout), 0);
    check_val("midrun rst carry",     64'(carry), 0);
    check_val("midrun rst zero",      64'(zero), 1);
    applyStimulus(2'b00, 4'd10, 16'h0001, "post_rst");
    checkOutput(16'h0400, 1'b0, "post_rst");

    // Random requests against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [3:0]   ra;
      logic [W-1:0] rdin;
      ro = 2'($urandom); ra = 4'($urandom); rdin = W'($urandom);
      if (i % 8 == 0) rdin = 16'h0000;
      model(ro, int'(ra), rdin, rd, rc);
      applyStimulus(ro, ra, rdin, $sformatf("rnd%0d", i));
      checkOutput(rd, rc, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
